neurorisc_lif_neuron: RTL and testbench
=======================================

NEURORISC_LIF_NEURON -- requirements
Module: neurorisc_lif_neuron

Interface
REQ-001 The block SHALL have a single clock, clk; reset is rst, synchronous and active-high.
REQ-002 Parameter THRESHOLD, default 100, is the unsigned firing threshold.
REQ-003 Parameter LEAK_SHIFT, default 4, is the leak per timestep, v -> v - (v >> LEAK_SHIFT).
REQ-004 Parameter REFRAC_TICKS, default 2, is the number of ticks after a spike whose inputs are discarded.
REQ-005 Parameter V_RESET, default 0, is the membrane value loaded on firing.
REQ-006 The ports SHALL be as follows:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- tick  input  1  single-cycle timestep strobe.
- spikeA / spikeB / spikeC / spikeD  input  32 each  unsigned synaptic weights from the upstream spike source.
- spike_out  output  1  one-cycle fire pulse.
- membrane  output  32  current membrane potential.
- busy  output  1  high whenever state is not IDLE.
- tick_overrun  output  1  sticky flag: a tick arrived while busy.

Function
REQ-007 The FSM SHALL have the states IDLE, ACC0, ACC1, ACC2, ACC3, LEAK and CMP.
REQ-008 In IDLE, a tick at edge N SHALL latch spikeA..D into internal registers and move the FSM to ACC0.
REQ-009 At the edge-N latch, if refrac_cnt != 0, all latched weights SHALL be forced to 0 and refrac_cnt decremented by 1.
REQ-010 ACC0..ACC3 (edges N+1..N+4) SHALL each add one latched weight to v, in the order A, B, C, D.
REQ-011 Each add SHALL saturate at 0xFFFFFFFF and never wrap.
REQ-012 LEAK (edge N+5) SHALL set v <= v - (v >> LEAK_SHIFT), using a logical shift.
REQ-013 CMP (edge N+6) SHALL, if v >= THRESHOLD: set spike_out <= 1, v <= V_RESET and refrac_cnt <= REFRAC_TICKS; otherwise it SHALL leave v unchanged.
REQ-014 From CMP the FSM SHALL always return to IDLE.
REQ-015 spike_out SHALL be high for exactly one cycle (edge N+6 to N+7) and low at all other times.
REQ-016 The minimum tick spacing SHALL be 7 cycles; a tick at edges N+1..N+6 is an overrun.
REQ-017 On an overrun, tick_overrun SHALL be set; the tick SHALL be dropped, and FSM state and datapath SHALL be unaffected.
REQ-018 Changes on spikeA..D after the latch edge SHALL have no effect on the current timestep.
REQ-019 membrane SHALL reflect v continuously, updated at each ACC, LEAK and CMP edge.
REQ-020 If THRESHOLD = 0, every timestep SHALL fire; REFRAC_TICKS = 0 SHALL disable the refractory period.

Reset
REQ-021 On rst high at a clock edge, the block SHALL apply: state = IDLE, v = 0, refrac_cnt = 0, spike_out = 0, tick_overrun = 0, and latched weights = 0.
REQ-022 Reset SHALL override tick and any in-progress state, including mid-ACC and CMP.
REQ-023 Reset SHALL NOT generate a spike_out pulse.
REQ-024 tick_overrun SHALL be cleared only by reset.

Structure
REQ-025 Package neurorisc_pkg SHALL hold the FSM state enum, the 32-bit weight width constant, and the default THRESHOLD, LEAK_SHIFT, REFRAC_TICKS and V_RESET values.
REQ-026 The saturating adder SHALL be implemented as a separate sub-module, neurorisc_sat_add32 (combinational, 32-bit unsigned, clamps to all-ones).
REQ-027 refrac_cnt width SHALL be $clog2(REFRAC_TICKS+1), with a minimum of 1.

Verification (defaults unless stated)
REQ-028 Scenario 1: A=10, B=1, C=2, D=5, one tick -> no spike, membrane=17, busy high for 6 cycles.
REQ-029 Scenario 2: the same inputs, ticks every 8 cycles -> membrane 17, 33, 48, 62, 75, 88; the 7th tick sums to 106, leaks to 100, spike_out pulses at N+6 and membrane=0.
REQ-030 Scenario 3: continue Scenario 2 with 3 more ticks -> ticks 8 and 9 are discarded (membrane stays 0, no spike); tick 10 gives membrane=17.
REQ-031 Scenario 4: A=D=0xFFFFFFFF, B=C=0 from v=0 -> the sum saturates at 0xFFFFFFFF, leak gives 0xF0000000, spike fires, membrane=0.
REQ-032 Scenario 5: a tick at N+3 during processing -> tick_overrun=1; the result equals the single-tick case (membrane=17); the flag persists until rst.
REQ-033 Scenario 6: rst asserted during ACC2 -> next cycle state IDLE, membrane=0, busy=0, no spike_out ever asserted for that timestep.

Source files
------------

// File: rtl/neurorisc_pkg.sv
// Shared types and defaults for the leaky integrate-and-fire neuron.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
//
// Contents: FSM state enum, latched weight bundle, weight width,
// default neuron parameters, refractory counter width helper.
package neurorisc_pkg;

  localparam int WEIGHT_W = 32;

  localparam logic [WEIGHT_W-1:0] DEF_THRESHOLD    = 32'd100;
  localparam int                  DEF_LEAK_SHIFT   = 4;
  localparam int                  DEF_REFRAC_TICKS = 2;
  localparam logic [WEIGHT_W-1:0] DEF_V_RESET      = 32'd0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ACC0 = 3'd1,
    ST_ACC1 = 3'd2,
    ST_ACC2 = 3'd3,
    ST_ACC3 = 3'd4,
    ST_LEAK = 3'd5,
    ST_CMP  = 3'd6
  } lif_state_e;

  // Synaptic weights captured on the accepted tick.
  typedef struct packed {
    logic [WEIGHT_W-1:0] a;
    logic [WEIGHT_W-1:0] b;
    logic [WEIGHT_W-1:0] c;
    logic [WEIGHT_W-1:0] d;
  } weights_t;

  // Counter width able to hold 0..ticks, never narrower than one bit so
  // a zero-length refractory period still elaborates a legal register.
  function automatic int refrac_cnt_w(input int ticks);
    int w;
    w = $clog2(ticks + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/neurorisc_sat_add32.sv
// Unsigned 32-bit adder that clamps to all-ones instead of wrapping.
// Latency: combinational.
// Backpressure: none.
//
// Ports: a_i, b_i - operands; sum_o - saturated sum.
module neurorisc_sat_add32
  import neurorisc_pkg::*;
(
  input  logic [WEIGHT_W-1:0] a_i,
  input  logic [WEIGHT_W-1:0] b_i,
  output logic [WEIGHT_W-1:0] sum_o
);

  // One extra bit catches the carry-out that signals overflow.
  logic [WEIGHT_W:0] raw_sum;

  assign raw_sum = {1'b0, a_i} + {1'b0, b_i};
  assign sum_o   = raw_sum[WEIGHT_W] ? '1 : raw_sum[WEIGHT_W-1:0];

endmodule

// File: rtl/neurorisc_lif_neuron.sv
// Leaky integrate-and-fire neuron: four weighted inputs, leak, threshold fire.
// Latency: tick at edge N -> membrane final and spike_out pulse at edge N+6.
// Backpressure: none; ticks arriving while busy are dropped and flagged.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   tick                single-cycle timestep strobe
//   spikeA..spikeD      unsigned synaptic weights, sampled on the accepted tick
//   spike_out           one-cycle fire pulse
//   membrane            current membrane potential
//   busy                timestep in progress
//   tick_overrun        sticky: a tick arrived while busy (cleared by rst only)
module neurorisc_lif_neuron
  import neurorisc_pkg::*;
#(
  parameter logic [WEIGHT_W-1:0] THRESHOLD    = DEF_THRESHOLD,
  parameter int                  LEAK_SHIFT   = DEF_LEAK_SHIFT,
  parameter int                  REFRAC_TICKS = DEF_REFRAC_TICKS,
  parameter logic [WEIGHT_W-1:0] V_RESET      = DEF_V_RESET
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic [WEIGHT_W-1:0] spikeA,
  input  logic [WEIGHT_W-1:0] spikeB,
  input  logic [WEIGHT_W-1:0] spikeC,
  input  logic [WEIGHT_W-1:0] spikeD,
  output logic                spike_out,
  output logic [WEIGHT_W-1:0] membrane,
  output logic                busy,
  output logic                tick_overrun
);

  localparam int REFRAC_W = refrac_cnt_w(REFRAC_TICKS);

  lif_state_e            state_q;
  weights_t              w_q;
  logic [WEIGHT_W-1:0]   v_q;
  logic [REFRAC_W-1:0]   refrac_q;
  logic                  spike_out_q;
  logic                  overrun_q;

  logic [WEIGHT_W-1:0]   add_op_d;
  logic [WEIGHT_W-1:0]   acc_sum_d;
  logic [WEIGHT_W-1:0]   leak_v_d;

  // One accumulate step per ACC state, so a single adder is shared and
  // the operand is chosen by the current state.
  always_comb begin
    add_op_d = '0;
    case (state_q)
      ST_ACC0: add_op_d = w_q.a;
      ST_ACC1: add_op_d = w_q.b;
      ST_ACC2: add_op_d = w_q.c;
      ST_ACC3: add_op_d = w_q.d;
      default: add_op_d = '0;
    endcase
  end

  neurorisc_sat_add32 u_sat_add (
    .a_i   (v_q),
    .b_i   (add_op_d),
    .sum_o (acc_sum_d)
  );

  // Logical shift: v is unsigned, so the leak never exceeds v itself.
  assign leak_v_d = v_q - (v_q >> LEAK_SHIFT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      w_q         <= '0;
      v_q         <= '0;
      refrac_q    <= '0;
      spike_out_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      // Pulse only lasts the cycle after CMP fires.
      spike_out_q <= 1'b0;

      // Any tick outside IDLE is an overrun; the FSM below ignores it.
      if (tick && (state_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (tick) begin
            // During the refractory window the timestep still runs
            // (so leak is applied) but contributes no input.
            if (refrac_q != '0) begin
              w_q      <= '0;
              refrac_q <= refrac_q - REFRAC_W'(1);
            end else begin
              w_q.a <= spikeA;
              w_q.b <= spikeB;
              w_q.c <= spikeC;
              w_q.d <= spikeD;
            end
            state_q <= ST_ACC0;
          end
        end
        ST_ACC0: begin
          v_q     <= acc_sum_d;
          state_q <= ST_ACC1;
        end
        ST_ACC1: begin
          v_q     <= acc_sum_d;
          state_q <= ST_ACC2;
        end
        ST_ACC2: begin
          v_q     <= acc_sum_d;
          state_q <= ST_ACC3;
        end
        ST_ACC3: begin
          v_q     <= acc_sum_d;
          state_q <= ST_LEAK;
        end
        ST_LEAK: begin
          v_q     <= leak_v_d;
          state_q <= ST_CMP;
        end
        ST_CMP: begin
          if (v_q >= THRESHOLD) begin
            spike_out_q <= 1'b1;
            v_q         <= V_RESET;
            refrac_q    <= REFRAC_W'(REFRAC_TICKS);
          end
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign spike_out    = spike_out_q;
  assign membrane     = v_q;
  assign busy         = (state_q != ST_IDLE);
  assign tick_overrun = overrun_q;

endmodule

// File: tb/tb_neurorisc_lif_neuron.sv
module tb_neurorisc_lif_neuron;

  localparam int          TB_THRESHOLD = 100;
  localparam int          TB_LEAK_DIV  = 16;   // 2**LEAK_SHIFT
  localparam int          TB_REFRAC    = 2;
  localparam logic [31:0] ALL_ONES     = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic [31:0] spikeA, spikeB, spikeC, spikeD;
  logic        spike_out;
  logic [31:0] membrane;
  logic        busy;
  logic        tick_overrun;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  neurorisc_lif_neuron dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .spikeA       (spikeA),
    .spikeB       (spikeB),
    .spikeC       (spikeC),
    .spikeD       (spikeD),
    .spike_out    (spike_out),
    .membrane     (membrane),
    .busy         (busy),
    .tick_overrun (tick_overrun)
  );

  typedef struct {
    logic        rst_before;
    logic [31:0] a, b, c, d;
    logic [31:0] exp_leak;   // membrane right after the LEAK edge
    logic [31:0] exp_final;  // membrane after CMP
    int          exp_spikes;
  } vec_t;

  vec_t vecs[11];

  // Behavioural model state.
  longint unsigned m_v;
  int              m_ref;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Starts at a negedge; issues one tick and observes the 8 cycles after
  // the latch edge. Inputs are scrambled right after the latch.
  task automatic run_step(input logic [31:0] a, b, c, d,
                          output logic [31:0] leak_v, final_v,
                          output int busy_n, spk_n, spk_pos);
    spikeA = a; spikeB = b; spikeC = c; spikeD = d;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    spikeA = $urandom; spikeB = $urandom; spikeC = $urandom; spikeD = $urandom;
    busy_n = 0; spk_n = 0; spk_pos = -1; leak_v = '0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      if (busy) busy_n++;
      if (spike_out) begin
        spk_n++;
        spk_pos = i;
      end
      if (i == 5) leak_v = membrane;
    end
    final_v = membrane;
  endtask

  // One timestep computed straight from the neuron's rules.
  task automatic model_step(input logic [31:0] a, b, c, d, output logic fired);
    longint unsigned w[4];
    w[0] = a; w[1] = b; w[2] = c; w[3] = d;
    if (m_ref > 0) begin
      for (int k = 0; k < 4; k++) w[k] = 0;
      m_ref--;
    end
    for (int k = 0; k < 4; k++) begin
      m_v = m_v + w[k];
      if (m_v > 64'hFFFF_FFFF) m_v = 64'hFFFF_FFFF;
    end
    m_v   = m_v - (m_v / TB_LEAK_DIV);
    fired = (m_v >= TB_THRESHOLD);
    if (fired) begin
      m_v   = 0;
      m_ref = TB_REFRAC;
    end
  endtask

  initial begin
    logic [31:0] lv, fv;
    int          bn, sn, sp;
    logic        fired;
    logic [31:0] ra, rb, rc, rd;

    spikeA = '0; spikeB = '0; spikeC = '0; spikeD = '0;
    rst = 1'b1; tick = 1'b0;

    // Ten spaced ticks of the same pattern, then a fresh saturation case.
    vecs[0]  = '{1'b1, 32'd10, 32'd1, 32'd2, 32'd5, 32'd17,  32'd17, 0};
    vecs[1]  = '{1'b0, 32'd10, 32'd1, 32'd2, 32'd5, 32'd33,  32'd33, 0};
    vecs[2]  = '{1'b0, 32'd10, 32'd1, 32'd2, 32'd5, 32'd48,  32'd48, 0};
    vecs[3]  = '{1'b0, 32'd10, 32'd1, 32'd2, 32'd5, 32'd62,  32'd62, 0};
    vecs[4]  = '{1'b0, 32'd10, 32'd1, 32'd2, 32'd5, 32'd75,  32'd75, 0};
    vecs[5]  = '{1'b0, 32'd10, 32'd1, 32'd2, 32'd5, 32'd88,  32'd88, 0};
    vecs[6]  = '{1'b0, 32'd10, 32'd1, 32'd2, 32'd5, 32'd100, 32'd0,  1};
    vecs[7]  = '{1'b0, 32'd10, 32'd1, 32'd2, 32'd5, 32'd0,   32'd0,  0};
    vecs[8]  = '{1'b0, 32'd10, 32'd1, 32'd2, 32'd5, 32'd0,   32'd0,  0};
    vecs[9]  = '{1'b0, 32'd10, 32'd1, 32'd2, 32'd5, 32'd17,  32'd17, 0};
    vecs[10] = '{1'b1, ALL_ONES, 32'd0, 32'd0, ALL_ONES, 32'hF000_0000, 32'd0, 1};

    // Reset state
    do_reset();
    chk("reset_membrane", membrane, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_spike", {31'd0, spike_out}, 32'd0);
    chk("reset_overrun", {31'd0, tick_overrun}, 32'd0);

    // Table-driven timesteps
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].rst_before) do_reset();
      run_step(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, lv, fv, bn, sn, sp);
      chk($sformatf("vec%0d_leak", i), lv, vecs[i].exp_leak);
      chk($sformatf("vec%0d_final", i), fv, vecs[i].exp_final);
      chk($sformatf("vec%0d_spikes", i), sn, vecs[i].exp_spikes);
      if (vecs[i].exp_spikes == 1) chk($sformatf("vec%0d_spike_pos", i), sp, 6);
      chk($sformatf("vec%0d_busy_cycles", i), bn, 6);
      chk($sformatf("vec%0d_overrun", i), {31'd0, tick_overrun}, 32'd0);
    end

    // Overrun at N+3: dropped, result unchanged, flag sticky until reset
    do_reset();
    spikeA = 10; spikeB = 1; spikeC = 2; spikeD = 5;
    tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    chk("ovr_flag_set", {31'd0, tick_overrun}, 32'd1);
    chk("ovr_still_busy", {31'd0, busy}, 32'd1);
    repeat (4) @(negedge clk);
    chk("ovr_membrane", membrane, 32'd17);
    chk("ovr_idle", {31'd0, busy}, 32'd0);
    run_step(32'd10, 32'd1, 32'd2, 32'd5, lv, fv, bn, sn, sp);
    chk("ovr_next_step", fv, 32'd33);
    chk("ovr_flag_sticky", {31'd0, tick_overrun}, 32'd1);
    do_reset();
    chk("ovr_flag_cleared", {31'd0, tick_overrun}, 32'd0);

    // Boundary: tick at N+6 is an overrun, tick at N+7 is accepted
    spikeA = 10; spikeB = 1; spikeC = 2; spikeD = 5;
    tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (5) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    chk("edge6_overrun", {31'd0, tick_overrun}, 32'd1);
    chk("edge6_membrane", membrane, 32'd17);
    @(negedge clk); tick = 1'b0;
    chk("edge7_accepted", {31'd0, busy}, 32'd1);
    repeat (6) @(negedge clk);
    chk("edge7_membrane", membrane, 32'd33);
    chk("edge7_idle", {31'd0, busy}, 32'd0);

    // Reset during ACC2 aborts the timestep without a spike
    do_reset();
    spikeA = 10; spikeB = 1; spikeC = 2; spikeD = 5;
    tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_partial_sum", membrane, 32'd11);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("midrst_membrane", membrane, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    sn = 0;
    for (int i = 0; i < 8; i++) begin
      if (spike_out) sn++;
      @(negedge clk);
    end
    chk("midrst_no_spike", sn, 0);
    chk("midrst_membrane_hold", membrane, 32'd0);

    // Reset wins over a simultaneous tick
    rst = 1'b1; tick = 1'b1;
    @(negedge clk);
    rst = 1'b0; tick = 1'b0;
    chk("rst_vs_tick_busy", {31'd0, busy}, 32'd0);

    // Randomized timesteps against the behavioural model
    do_reset();
    m_v = 0; m_ref = 0;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        ra = $urandom; rb = $urandom; rc = $urandom; rd = $urandom;
      end else begin
        ra = $urandom_range(0, 40); rb = $urandom_range(0, 40);
        rc = $urandom_range(0, 40); rd = $urandom_range(0, 40);
      end
      model_step(ra, rb, rc, rd, fired);
      run_step(ra, rb, rc, rd, lv, fv, bn, sn, sp);
      chk($sformatf("rnd%0d_membrane", i), fv, m_v[31:0]);
      chk($sformatf("rnd%0d_spikes", i), sn, fired ? 1 : 0);
      if (fired) chk($sformatf("rnd%0d_spike_pos", i), sp, 6);
    end
    chk("rnd_no_overrun", {31'd0, tick_overrun}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
